// File: rtl/red_pitaya_fads_pkg.sv
// Shared definitions for the FADS sorter/logger register maps and droplet record layout.
// Offsets are bus offsets within the block (address bits [19:0]).
package red_pitaya_fads_pkg;

  localparam logic [19:0] REG_CTRL   = 20'h00;
  localparam logic [19:0] REG_STATUS = 20'h04;
  localparam logic [19:0] REG_OVF    = 20'h08;
  localparam logic [19:0] REG_TS_NOW = 20'h0C;
  localparam logic [19:0] REG_POP_TS = 20'h10;
  localparam logic [19:0] REG_HOLD_W = 20'h14;
  localparam logic [19:0] REG_HOLD_M = 20'h18;

  typedef enum logic [1:0] {
    CLS_NEG      = 2'b00,
    CLS_POS      = 2'b01,
    CLS_LOW_INT  = 2'b10,
    CLS_HIGH_INT = 2'b11
  } evt_class_e;

  localparam int META_SORTED_BIT = 31;
  localparam int META_CLASS_MSB  = 30;
  localparam int META_CLASS_LSB  = 29;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_CLR_BIT      = 1;
  localparam int STATUS_EMPTY_BIT  = 30;
  localparam int STATUS_FULL_BIT   = 31;

  typedef enum logic [1:0] {
    BUS_IDLE    = 2'd0,
    BUS_RD_WAIT = 2'd1,
    BUS_ACK     = 2'd2
  } bus_state_e;

endpackage

// File: rtl/red_pitaya_fads_logger_ram.sv
// Simple dual-port synchronous RAM holding droplet records.
// One write port, one read port, read data valid one cycle after the address.
module red_pitaya_fads_logger_ram #(
  parameter int AW = 10,
  parameter int DW = 96
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  always_comb rdata_d = mem[raddr_i];

  // NOTE: the array has no reset so it maps onto block RAM; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/red_pitaya_fads_logger.sv
// Per-droplet event logger: timestamps sorter evaluations into a circular FIFO
// and exposes them to host software through a small bus register map.
module red_pitaya_fads_logger
  import red_pitaya_fads_pkg::*;
#(
  parameter int AW  = 10,
  parameter int DWT = 14,
  parameter int MEM = 32
) (
  input  logic            adc_clk_i,
  input  logic            adc_rst_i,
  input  logic            evt_valid_i,
  input  logic [DWT-1:0]  evt_intensity_i,
  input  logic [MEM-1:0]  evt_width_i,
  input  logic [1:0]      evt_class_i,
  input  logic            evt_sorted_i,
  input  logic [31:0]     sys_addr,
  input  logic [31:0]     sys_wdata,
  input  logic [3:0]      sys_sel,
  input  logic            sys_wen,
  input  logic            sys_ren,
  output logic [31:0]     sys_rdata,
  output logic            sys_err,
  output logic            sys_ack
);

  localparam int RW = 3 * MEM;

  logic [MEM-1:0] ts_q, ts_d;
  logic [MEM-1:0] ovf_q, ovf_d;
  logic [AW-1:0]  wp_q, wp_d;
  logic [AW-1:0]  rp_q, rp_d;
  logic [AW:0]    count_q, count_d;
  logic           enable_q, enable_d;
  logic [MEM-1:0] hold_w_q, hold_w_d;
  logic [MEM-1:0] hold_m_q, hold_m_d;
  logic           pop_ok_q, pop_ok_d;
  logic [31:0]    sys_rdata_q, sys_rdata_d;
  bus_state_e     state_q, state_d;

  logic           full, empty, push, drop, clear, pop_commit, bus_idle;
  logic [19:0]    reg_addr;
  logic [MEM-1:0] evt_meta;
  logic [RW-1:0]  wr_data, rd_data;
  logic [31:0]    reg_rdata, status_word;
  logic           unused_bus_bits;

  assign unused_bus_bits = ^{sys_sel, sys_addr[31:20], sys_wdata[31:2]};

  assign reg_addr   = sys_addr[19:0];
  assign bus_idle   = (state_q == BUS_IDLE);
  assign full       = count_q[AW];
  assign empty      = (count_q == '0);
  assign clear      = bus_idle && sys_wen && (reg_addr == REG_CTRL) && sys_wdata[CTRL_CLR_BIT];
  assign pop_commit = (state_q == BUS_RD_WAIT) && pop_ok_q;
  // Fullness comes from the registered count, so a same-cycle pop cannot admit a push.
  assign push       = evt_valid_i && enable_q && !full && !clear;
  assign drop       = evt_valid_i && enable_q && full && !clear;

  always_comb begin
    evt_meta = '0;
    evt_meta[META_SORTED_BIT]               = evt_sorted_i;
    evt_meta[META_CLASS_MSB:META_CLASS_LSB] = evt_class_i;
    evt_meta[DWT-1:0]                       = evt_intensity_i;
  end

  assign wr_data = {ts_q, evt_width_i, evt_meta};

  red_pitaya_fads_logger_ram #(
    .AW (AW),
    .DW (RW)
  ) u_ram (
    .clk_i   (adc_clk_i),
    .we_i    (push),
    .waddr_i (wp_q),
    .wdata_i (wr_data),
    .raddr_i (rp_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    status_word                   = '0;
    status_word[AW:0]             = count_q;
    status_word[STATUS_EMPTY_BIT] = empty;
    status_word[STATUS_FULL_BIT]  = full;
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_CTRL:   reg_rdata[CTRL_EN_BIT] = enable_q;
      REG_STATUS: reg_rdata = status_word;
      REG_OVF:    reg_rdata = 32'(ovf_q);
      REG_TS_NOW: reg_rdata = 32'(ts_q);
      REG_HOLD_W: reg_rdata = 32'(hold_w_q);
      REG_HOLD_M: reg_rdata = 32'(hold_m_q);
      default:    reg_rdata = '0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    ts_d        = ts_q + MEM'(1);
    ovf_d       = ovf_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    enable_d    = enable_q;
    hold_w_d    = hold_w_q;
    hold_m_d    = hold_m_q;
    pop_ok_d    = pop_ok_q;
    sys_rdata_d = '0;
    state_d     = state_q;

    if (push) wp_d = wp_q + AW'(1);
    if (pop_commit) begin
      rp_d     = rp_q + AW'(1);
      hold_w_d = rd_data[2*MEM-1 -: MEM];
      hold_m_d = rd_data[MEM-1:0];
    end
    case ({push, pop_commit})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop && (ovf_q != '1)) ovf_d = ovf_q + MEM'(1);

    case (state_q)
      BUS_IDLE: begin
        if (sys_wen) begin
          state_d = BUS_ACK;
          if (reg_addr == REG_CTRL) enable_d = sys_wdata[CTRL_EN_BIT];
        end else if (sys_ren) begin
          if (reg_addr == REG_POP_TS) begin
            state_d  = BUS_RD_WAIT;
            pop_ok_d = !empty;
          end else begin
            state_d     = BUS_ACK;
            sys_rdata_d = reg_rdata;
          end
        end
      end
      BUS_RD_WAIT: begin
        state_d     = BUS_ACK;
        sys_rdata_d = pop_ok_q ? 32'(rd_data[RW-1 -: MEM]) : '0;
      end
      default: state_d = BUS_IDLE;
    endcase

    if (clear) begin
      wp_d     = '0;
      rp_d     = '0;
      count_d  = '0;
      ovf_d    = '0;
      hold_w_d = '0;
      hold_m_d = '0;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      ts_q        <= '0;
      ovf_q       <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      enable_q    <= 1'b1;
      hold_w_q    <= '0;
      hold_m_q    <= '0;
      pop_ok_q    <= 1'b0;
      sys_rdata_q <= '0;
      state_q     <= BUS_IDLE;
    end else begin
      ts_q        <= ts_d;
      ovf_q       <= ovf_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      enable_q    <= enable_d;
      hold_w_q    <= hold_w_d;
      hold_m_q    <= hold_m_d;
      pop_ok_q    <= pop_ok_d;
      sys_rdata_q <= sys_rdata_d;
      state_q     <= state_d;
    end
  end

  assign sys_rdata = sys_rdata_q;
  assign sys_ack   = (state_q == BUS_ACK);
  assign sys_err   = 1'b0;

endmodule
